// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FREEZE  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_freeze;
    } pipe_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until all-ones is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline with performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = pipe_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             i_wait,
    input  logic             d_wait,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t  state;
    hz_state_t  state_n;
    logic       pend_redir;
    logic       pend_redir_n;
    logic       flush_inc;
    logic       load_use;
    logic       redirect;
    pipe_ctrl_t ctrl;
    pipe_ctrl_t ctrl_out;

    // Hazard detection: load in EX feeding a source read in ID.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        redirect = ex_redirect || pend_redir;
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pend_redir <= 1'b0;
        end else begin
            state      <= state_n;
            pend_redir <= pend_redir_n;
        end
    end

    // Next state and control outputs, resolved in priority order.
    always_comb begin
        ctrl         = '0;
        state_n      = state;
        pend_redir_n = pend_redir;
        flush_inc    = 1'b0;
        if (d_wait) begin
            // Memory stall freezes everything; a redirect seen now is remembered.
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.pipe_freeze = 1'b1;
            state_n          = FREEZE;
            if (ex_redirect) begin
                pend_redir_n = 1'b1;
            end
        end else if (redirect) begin
            // Squash IF/ID and ID/EX; any load-use stall is moot.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            pend_redir_n     = 1'b0;
            flush_inc        = 1'b1;
            state_n          = RUN;
        end else if (state == LDSTALL) begin
            // Second cycle of a load-use: let the held instruction go.
            state_n = RUN;
        end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            state_n          = LDSTALL;
        end else if (i_wait) begin
            // Fetch not ready: hold PC and feed a NOP into decode.
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            state_n          = RUN;
        end else begin
            state_n = RUN;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        ctrl_out = reset ? pipe_ctrl_t'('0) : ctrl;
    end

    assign pc_stall    = ctrl_out.pc_stall;
    assign if_id_stall = ctrl_out.if_id_stall;
    assign if_id_flush = ctrl_out.if_id_flush;
    assign id_ex_flush = ctrl_out.id_ex_flush;
    assign pipe_freeze = ctrl_out.pipe_freeze;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl_out.pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
